spi_rx: RTL and testbench
=========================

Name: spi_rx

Overview:
- SPI 8-bit slave receiver, the input-side counterpart of the SPI output driver.
- Samples externally driven sck/sdi/cs_/dc pins on the 62.5 MHz system clock and deserializes MSB-first bytes.
- Tags each byte with its D/C bit and queues it in a small FWFT FIFO.
- The MIPS reads the FIFO through a memory-mapped chip select; the top level decodes the address and drives `rd`.
- Wire protocol: sck idles high, data changes on sck falling edge, sampled on sck rising edge, cs_ active low, D/C level valid for the whole byte.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- SYNC_STAGES, 2, synchronizer flops per input pin (≥2).

Ports:
- clk_62p5mhz  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sck_in  in  1  external SPI clock (async, ≤1.25 MHz)
- sdi_in  in  1  external serial data (async)
- cs_in_  in  1  external chip select, active low (async)
- dc_in  in  1  external data/command flag, 1=data, 0=cmd (async)
- rd  in  1  pop strobe (one cycle = one pop)
- clr_err  in  1  clears sticky error flags
- rdata  out  9  FIFO head {dc, byte[7:0]}, valid when `valid`=1
- valid  out  1  FIFO not empty
- level  out  3  FIFO occupancy 0..DEPTH
- overrun  out  1  sticky: byte completed while FIFO full
- frame_err  out  1  sticky: cs_ deasserted with 1..7 bits shifted
- busy  out  1  cs_ (synchronized) low

Behaviour:
- Reset values: all synchronizer flops = idle levels (sck=1, cs_=1, sdi=0, dc=0); state=IDLE; bit count=0; shift register=0; FIFO empty.
  - Output reset values: rdata=0, valid=0, level=0, overrun=0, frame_err=0, busy=0.
  - Reset asserted mid-byte discards the partial byte and the FIFO contents; no flags are set.
- Synchronization: each pin passes through SYNC_STAGES flops. sck_prev is one additional flop on synced sck.
  - sck_rise = sck_s & ~sck_prev.
  - All four pins share the same path depth, so they stay mutually aligned.
- State machine:
  - IDLE: busy=0, bit count held at 0. Go to SHIFT when cs_s=0.
  - SHIFT: busy=1. On sck_rise: shift register ← {sr[6:0], sdi_s} and bit count++.
    - On the 8th rise: the completed byte and dc_s (sampled on that same edge) are pushed, bit count→0, stay in SHIFT.
  - SHIFT with cs_s=1 → IDLE.
    - If bit count ≠ 0: set frame_err and discard the partial byte.
    - If bit count = 0: no flag.
  - If cs_s rises on the same cycle as an sck_rise, the cs_ deassertion wins and the edge is ignored.
- Latency: a pin edge at the 8th sck rise produces valid/rdata updated after SYNC_STAGES+1 clk edges (3 with defaults).
- FIFO: first-word fall-through. rdata always shows the head and is 0 when empty.
  - Pop when rd && valid. rd while empty is ignored: no underflow, level stays 0.
  - Push while full (no simultaneous pop): byte dropped, overrun set, contents unchanged.
  - Push and pop on the same cycle:
    - When full: both occur, level unchanged, overrun not set.
    - When empty: the push occurs and the pop is ignored, so level=1 next cycle.
  - Pointers wrap modulo DEPTH. level uses a separate up/down counter.
- Flags: overrun and frame_err are sticky until clr_err. If clr_err and a new error event coincide, the flag is set.
- Arithmetic: bit count is 3 bits, 0..7; wrap 7→0 is the push event. level width is clog2(DEPTH+1).

Decomposition:
- Package spi_pkg holds:
  - state encodings SPI_RX_IDLE/SPI_RX_SHIFT;
  - SPI_DATA=1'b1 and SPI_CMD=1'b0;
  - SPI_BITS=8;
  - the sck idle level (1).
- One sub-module, spi_rx_fifo: parameterized DEPTH×9-bit FWFT FIFO with push, pop, full, empty and level. The synchronizer and the FSM stay in spi_rx.

Test Plan:
- Send byte 0xA5 with dc=1 at 1.25 MHz, cs_ low throughout → valid=1, rdata=9'h1A5, level=1, exactly 3 clk after the 8th sck rise. Pulse rd → valid=0, level=0.
- Send 0x3C (dc=0) then 0xFF (dc=1) within one cs_ frame → rdata=9'h03C; after rd, rdata=9'h1FF; no flags set.
- Deassert cs_ after 5 bits of 0x81, then send a full 0x42 → frame_err=1, only 9'h142 queued. clr_err → frame_err=0.
- Send 5 bytes 0x01..0x05 with no rd (DEPTH=4) → level=4, overrun=1, pop order 0x01..0x04. On the 5th push coinciding with rd while full: level stays 4, overrun=0.
- rd while empty → level=0, valid=0, no state change. Apply reset mid-byte after 3 bits, then send 0x99 → only 0x99 received, flags=0.
- cs_ rising on the same cycle as the 8th synced sck rise → byte dropped, frame_err=1, level unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave receive path.
// Holds FSM encodings, the D/C tag values and the wire idle levels.
package spi_pkg;

    typedef enum logic {
        SPI_RX_IDLE  = 1'b0,
        SPI_RX_SHIFT = 1'b1
    } spi_rx_state_t;

    localparam logic SPI_DATA     = 1'b1;
    localparam logic SPI_CMD      = 1'b0;
    localparam int   SPI_BITS     = 8;
    localparam logic SPI_SCK_IDLE = 1'b1;

    // One queued entry: D/C tag above the received byte.
    typedef struct packed {
        logic                dc;
        logic [SPI_BITS-1:0] data;
    } spi_word_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// First-word fall-through FIFO holding tagged SPI bytes.
// rdata shows the head combinationally and reads as zero while empty.
module spi_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9,
    localparam int LW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk_62p5mhz,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    // A pop on an empty FIFO is ignored; a push into a full FIFO only
    // lands when the same cycle frees a slot.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_62p5mhz) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_62p5mhz) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/spi_rx.sv
// SPI mode-3 style slave receiver: synchronizes the pins, shifts MSB-first
// bytes on sck rising edges and queues {dc, byte} for the CPU to pop.
// Read handshake: rdata is valid whenever valid=1; a word is consumed on
// every cycle where rd && valid, and rd with valid=0 has no effect.
module spi_rx
    import spi_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk_62p5mhz,
    input  logic                       reset,
    input  logic                       sck_in,
    input  logic                       sdi_in,
    input  logic                       cs_in_,
    input  logic                       dc_in,
    input  logic                       rd,
    input  logic                       clr_err,
    output logic [SPI_BITS:0]          rdata,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overrun,
    output logic                       frame_err,
    output logic                       busy
);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic                   sck_prev;
    logic                   sck_s;
    logic                   sdi_s;
    logic                   cs_s;
    logic                   dc_s;
    logic                   sck_rise;

    spi_rx_state_t          state;
    logic [2:0]             bit_cnt;
    logic [SPI_BITS-1:0]    shift_reg;
    logic                   byte_done;
    logic                   fifo_full;
    logic                   fifo_empty;
    spi_word_t              push_word;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign dc_s     = dc_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;

    // All four pins share one path depth so sdi/dc/cs_ stay aligned with sck.
    always_ff @(posedge clk_62p5mhz) begin
        if (reset) begin
            sck_sync <= {SYNC_STAGES{SPI_SCK_IDLE}};
            cs_sync  <= '1;
            sdi_sync <= '0;
            dc_sync  <= '0;
            sck_prev <= SPI_SCK_IDLE;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_in};
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_in_};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi_in};
            dc_sync  <= {dc_sync[SYNC_STAGES-2:0], dc_in};
            sck_prev <= sck_s;
        end
    end

    // cs_ deassertion takes priority over an sck edge seen on the same cycle.
    assign byte_done = (state == SPI_RX_SHIFT) && !cs_s && sck_rise
                       && (bit_cnt == 3'(SPI_BITS - 1));
    assign push_word = '{dc: dc_s, data: {shift_reg[SPI_BITS-2:0], sdi_s}};

    always_ff @(posedge clk_62p5mhz) begin
        if (reset) begin
            state     <= SPI_RX_IDLE;
            bit_cnt   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (clr_err) frame_err <= 1'b0;
            case (state)
                SPI_RX_IDLE: begin
                    bit_cnt <= '0;
                    if (!cs_s) begin
                        state <= SPI_RX_SHIFT;
                        busy  <= 1'b1;
                    end
                end
                SPI_RX_SHIFT: begin
                    if (cs_s) begin
                        state     <= SPI_RX_IDLE;
                        busy      <= 1'b0;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        if (bit_cnt != '0) frame_err <= 1'b1;
                    end else if (sck_rise) begin
                        shift_reg <= {shift_reg[SPI_BITS-2:0], sdi_s};
                        bit_cnt   <= bit_cnt + 3'd1;
                    end
                end
                default: begin
                    state <= SPI_RX_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_62p5mhz) begin
        if (reset) begin
            overrun <= 1'b0;
        end else begin
            if (clr_err) overrun <= 1'b0;
            if (byte_done && fifo_full && !rd) overrun <= 1'b1;
        end
    end

    spi_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SPI_BITS + 1)
    ) u_fifo (
        .clk_62p5mhz (clk_62p5mhz),
        .reset       (reset),
        .push        (byte_done),
        .pop         (rd),
        .wdata       (push_word),
        .rdata       (rdata),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .level       (level)
    );

    assign valid = ~fifo_empty;

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: drives the SPI pins from tasks and checks the FIFO view
// against constants and a queue-based model of the received words.
module tb_spi_rx;
    import spi_pkg::*;

    localparam int DEPTH = 4;
    localparam int HALF  = 25;  // sck half period in clk cycles (1.25 MHz)

    logic       clk_62p5mhz = 1'b0;
    logic       reset       = 1'b1;
    logic       sck_in      = 1'b1;
    logic       sdi_in      = 1'b0;
    logic       cs_in_      = 1'b1;
    logic       dc_in       = 1'b0;
    logic       rd          = 1'b0;
    logic       clr_err     = 1'b0;
    logic [8:0] rdata;
    logic       valid;
    logic [2:0] level;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [8:0] exp_q[$];
    logic       exp_ovr;
    logic       exp_ferr;

    spi_rx #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk_62p5mhz (clk_62p5mhz),
        .reset       (reset),
        .sck_in      (sck_in),
        .sdi_in      (sdi_in),
        .cs_in_      (cs_in_),
        .dc_in       (dc_in),
        .rd          (rd),
        .clr_err     (clr_err),
        .rdata       (rdata),
        .valid       (valid),
        .level       (level),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #8 clk_62p5mhz = ~clk_62p5mhz;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_62p5mhz);
        #1;
    endtask

    task automatic spi_bit(input logic v, input logic cs_up);
        sck_in = 1'b0;
        sdi_in = v;
        tick(HALF);
        sck_in = 1'b1;
        if (cs_up) cs_in_ = 1'b1;
        tick(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        dc_in = dc;
        for (int i = 7; i >= 0; i--) spi_bit(b[i], 1'b0);
    endtask

    task automatic cs_low();
        cs_in_ = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        cs_in_ = 1'b1;
        tick(HALF);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic dc);
        cs_low();
        send_byte(b, dc);
        cs_high();
    endtask

    task automatic pop_once();
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    task automatic model_push(input logic [8:0] w);
        if (exp_q.size() < DEPTH) exp_q.push_back(w);
        else exp_ovr = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        tick(4);
        reset = 1'b0;
        tick(3);
        n_cmp++;
        if ({rdata, valid, level, overrun, frame_err, busy} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0",
                     {rdata, valid, level, overrun, frame_err, busy});
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] b;
        b = 8'hA5;
        cs_low();
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL busy_frame: got %b want 1", busy); end
        dc_in = SPI_DATA;
        for (int i = 7; i >= 1; i--) spi_bit(b[i], 1'b0);
        sck_in = 1'b0;
        sdi_in = b[0];
        tick(HALF);
        sck_in = 1'b1;
        tick(2);
        n_cmp++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL latency_early: got valid=%b want 0", valid); end
        tick(1);
        n_cmp++;
        if ({valid, rdata, level} !== {1'b1, 9'h1A5, 3'd1}) begin
            n_err++;
            $display("FAIL latency_a5: got valid=%b rdata=%h level=%0d want 1 1a5 1", valid, rdata, level);
        end
        tick(HALF - 3);
        cs_high();
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL busy_idle: got %b want 0", busy); end
        pop_once();
        n_cmp++;
        if ({valid, level, rdata} !== {1'b0, 3'd0, 9'h0}) begin
            n_err++;
            $display("FAIL a5_pop: got valid=%b level=%0d rdata=%h want 0 0 0", valid, level, rdata);
        end
    endtask

    task automatic test_two_bytes();
        cs_low();
        send_byte(8'h3C, SPI_CMD);
        send_byte(8'hFF, SPI_DATA);
        cs_high();
        n_cmp++;
        if ({rdata, level} !== {9'h03C, 3'd2}) begin
            n_err++;
            $display("FAIL two_first: got rdata=%h level=%0d want 03c 2", rdata, level);
        end
        pop_once();
        n_cmp++;
        if (rdata !== 9'h1FF) begin n_err++; $display("FAIL two_second: got %h want 1ff", rdata); end
        n_cmp++;
        if ({overrun, frame_err} !== 2'b00) begin
            n_err++;
            $display("FAIL two_flags: got %b%b want 00", overrun, frame_err);
        end
        pop_once();
    endtask

    task automatic test_frame_err();
        logic [7:0] b;
        b = 8'h81;
        cs_low();
        dc_in = SPI_DATA;
        for (int i = 7; i >= 3; i--) spi_bit(b[i], 1'b0);
        cs_high();
        n_cmp++;
        if ({frame_err, level} !== {1'b1, 3'd0}) begin
            n_err++;
            $display("FAIL ferr_set: got ferr=%b level=%0d want 1 0", frame_err, level);
        end
        send_frame(8'h42, SPI_DATA);
        n_cmp++;
        if ({level, rdata} !== {3'd1, 9'h142}) begin
            n_err++;
            $display("FAIL ferr_next: got level=%0d rdata=%h want 1 142", level, rdata);
        end
        pop_once();
        pulse_clr();
        n_cmp++;
        if (frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_clr: got %b want 0", frame_err); end
    endtask

    task automatic test_overrun();
        cs_low();
        for (int i = 1; i <= 5; i++) send_byte(8'(i), SPI_DATA);
        cs_high();
        n_cmp++;
        if ({level, overrun} !== {3'd4, 1'b1}) begin
            n_err++;
            $display("FAIL ovr_full: got level=%0d ovr=%b want 4 1", level, overrun);
        end
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (rdata !== {1'b1, 8'(k)}) begin
                n_err++;
                $display("FAIL ovr_order: got %h want %h", rdata, {1'b1, 8'(k)});
            end
            pop_once();
        end
        n_cmp++;
        if (valid !== 1'b0) begin n_err++; $display("FAIL ovr_drain: got valid=%b want 0", valid); end
        pulse_clr();
        n_cmp++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clr: got %b want 0", overrun); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] b;
        b = 8'h0A;
        cs_low();
        for (int i = 6; i <= 9; i++) send_byte(8'(i), SPI_DATA);
        dc_in = SPI_DATA;
        for (int i = 7; i >= 1; i--) spi_bit(b[i], 1'b0);
        sck_in = 1'b0;
        sdi_in = b[0];
        tick(HALF);
        sck_in = 1'b1;
        tick(2);
        rd = 1'b1;
        tick(1);
        rd = 1'b0;
        n_cmp++;
        if ({level, overrun} !== {3'd4, 1'b0}) begin
            n_err++;
            $display("FAIL pushpop_full: got level=%0d ovr=%b want 4 0", level, overrun);
        end
        tick(HALF - 3);
        cs_high();
        for (int k = 7; k <= 10; k++) begin
            n_cmp++;
            if (rdata !== {1'b1, 8'(k)}) begin
                n_err++;
                $display("FAIL pushpop_order: got %h want %h", rdata, {1'b1, 8'(k)});
            end
            pop_once();
        end
    endtask

    task automatic test_empty_rd();
        rd = 1'b1;
        tick(3);
        rd = 1'b0;
        tick(1);
        n_cmp++;
        if ({level, valid, rdata, overrun} !== {3'd0, 1'b0, 9'h0, 1'b0}) begin
            n_err++;
            $display("FAIL empty_rd: got level=%0d valid=%b rdata=%h ovr=%b want 0 0 0 0",
                     level, valid, rdata, overrun);
        end
    endtask

    task automatic test_reset_mid_byte();
        logic [7:0] b;
        b = 8'hE7;
        cs_low();
        dc_in = SPI_DATA;
        for (int i = 7; i >= 5; i--) spi_bit(b[i], 1'b0);
        reset  = 1'b1;
        cs_in_ = 1'b1;
        sck_in = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(HALF);
        send_frame(8'h99, SPI_DATA);
        n_cmp++;
        if ({level, rdata, overrun, frame_err} !== {3'd1, 9'h199, 2'b00}) begin
            n_err++;
            $display("FAIL rst_mid: got level=%0d rdata=%h flags=%b%b want 1 199 00",
                     level, rdata, overrun, frame_err);
        end
        pop_once();
    endtask

    task automatic test_cs_sck_collide();
        logic [7:0] b;
        b = 8'h5A;
        send_frame(8'h11, SPI_CMD);
        cs_low();
        dc_in = SPI_DATA;
        for (int i = 7; i >= 1; i--) spi_bit(b[i], 1'b0);
        spi_bit(b[0], 1'b1);
        tick(HALF);
        n_cmp++;
        if ({frame_err, level, rdata} !== {1'b1, 3'd1, 9'h011}) begin
            n_err++;
            $display("FAIL collide: got ferr=%b level=%0d rdata=%h want 1 1 011",
                     frame_err, level, rdata);
        end
        pop_once();
        pulse_clr();
    endtask

    task automatic test_random();
        int         nb;
        int         np;
        logic [7:0] b;
        logic       dc;
        exp_q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        for (int f = 0; f < 6; f++) begin
            nb = $urandom_range(1, 3);
            cs_low();
            for (int j = 0; j < nb; j++) begin
                b  = 8'($urandom);
                dc = 1'($urandom);
                send_byte(b, dc);
                model_push({dc, b});
            end
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom);
                for (int i = $urandom_range(1, 7); i > 0; i--) spi_bit(b[i], 1'b0);
                exp_ferr = 1'b1;
            end
            cs_high();
            n_cmp++;
            if ({level, rdata, overrun, frame_err} !==
                {3'(exp_q.size()), (exp_q.size() != 0) ? exp_q[0] : 9'h0, exp_ovr, exp_ferr}) begin
                n_err++;
                $display("FAIL rand_frame%0d: got level=%0d rdata=%h ovr=%b ferr=%b want %0d %h %b %b",
                         f, level, rdata, overrun, frame_err, exp_q.size(),
                         (exp_q.size() != 0) ? exp_q[0] : 9'h0, exp_ovr, exp_ferr);
            end
            np = $urandom_range(0, exp_q.size());
            for (int p = 0; p < np; p++) begin
                n_cmp++;
                if (rdata !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL rand_pop: got %h want %h", rdata, exp_q[0]);
                end
                pop_once();
                void'(exp_q.pop_front());
            end
        end
        while (exp_q.size() != 0) begin
            n_cmp++;
            if (rdata !== exp_q[0]) begin
                n_err++;
                $display("FAIL rand_drain: got %h want %h", rdata, exp_q[0]);
            end
            pop_once();
            void'(exp_q.pop_front());
        end
        n_cmp++;
        if (level !== 3'd0) begin n_err++; $display("FAIL rand_empty: got %0d want 0", level); end
        pulse_clr();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_two_bytes();
        test_frame_err();
        test_overrun();
        test_full_push_pop();
        test_empty_rd();
        test_reset_mid_byte();
        test_cs_sck_collide();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
